control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multicycle MIPS-subset control FSM: fetch/decode prefix, per-class execute
// sequences, optional overflow trap enabled by the OVERFLOW_TRAP_EN macro.
module control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       alu_overflow,
   output logic       pc_load,
   output logic       ir_load,
   output logic       mem_write,
   output logic       reg_write,
   output logic       regA_load,
   output logic       regB_load,
   output logic       aluout_load,
   output logic       epc_load,
   output logic [2:0] alu_op,
   output logic [1:0] mem_addr_sel,
   output logic [1:0] wreg_sel,
   output logic [2:0] wdata_sel,
   output logic       alu_srcA_sel,
   output logic [1:0] alu_srcB_sel,
   output logic [1:0] pc_src
);

   // state     | meaning
   // RESET     | held in reset, all outputs 0
   // FETCH0/1  | instruction memory read at PC
   // FETCH2    | IR <= mem, PC <= PC+4
   // DECODE    | A/B <= regs, ALUOut <= branch target, dispatch
   // R_EXEC    | ALUOut <= A op B
   // R_WB      | rd <= ALUOut
   // ADDI_EXEC | ALUOut <= A + imm
   // ADDI_WB   | rt <= ALUOut
   // LW_ADDR   | ALUOut <= A + imm
   // LW_MEM    | data memory read at ALUOut
   // LW_WAIT   | data memory read held
   // LW_WB     | rt <= memory data
   // SW_ADDR   | ALUOut <= A + imm
   // SW_MEM    | mem[ALUOut] <= B
   // BEQ/BNE   | compare A-B, PC <= ALUOut if taken
   // JUMP      | PC <= jump target
   // EXC0      | EPC <= PC-4 (trap build only)
   // EXC1      | PC <= exception vector (trap build only)

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [2:0] ALU_PASSA = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;

   typedef enum logic [4:0] {
      RESET,
      FETCH0,
      FETCH1,
      FETCH2,
      DECODE,
      R_EXEC,
      R_WB,
      ADDI_EXEC,
      ADDI_WB,
      LW_ADDR,
      LW_MEM,
      LW_WAIT,
      LW_WB,
      SW_ADDR,
      SW_MEM,
      BEQ,
      BNE,
      JUMP
`ifdef OVERFLOW_TRAP_EN
      ,
      EXC0,
      EXC1
`endif
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] r_alu_op;

`ifndef OVERFLOW_TRAP_EN
   logic unused_alu_overflow;
   assign unused_alu_overflow = alu_overflow;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RESET;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      case (funct)
         FN_ADD:  r_alu_op = ALU_ADD;
         FN_SUB:  r_alu_op = ALU_SUB;
         FN_AND:  r_alu_op = ALU_AND;
         default: r_alu_op = ALU_PASSA;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      pc_load      = 1'b0;
      ir_load      = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      regA_load    = 1'b0;
      regB_load    = 1'b0;
      aluout_load  = 1'b0;
      epc_load     = 1'b0;
      alu_op       = ALU_PASSA;
      mem_addr_sel = 2'b00;
      wreg_sel     = 2'b00;
      wdata_sel    = 3'b000;
      alu_srcA_sel = 1'b0;
      alu_srcB_sel = 2'b00;
      pc_src       = 2'b00;

      case (state)
         RESET:  state_nxt = FETCH0;
         FETCH0: state_nxt = FETCH1;
         FETCH1: state_nxt = FETCH2;
         FETCH2: begin
            ir_load      = 1'b1;
            pc_load      = 1'b1;
            alu_srcB_sel = 2'b01;
            alu_op       = ALU_ADD;
            state_nxt    = DECODE;
         end
         DECODE: begin
            regA_load    = 1'b1;
            regB_load    = 1'b1;
            aluout_load  = 1'b1;
            alu_srcB_sel = 2'b11;
            alu_op       = ALU_ADD;
            case (opcode)
               OP_RTYPE: state_nxt = R_EXEC;
               OP_ADDI:  state_nxt = ADDI_EXEC;
               OP_LW:    state_nxt = LW_ADDR;
               OP_SW:    state_nxt = SW_ADDR;
               OP_BEQ:   state_nxt = BEQ;
               OP_BNE:   state_nxt = BNE;
               OP_J:     state_nxt = JUMP;
               default:  state_nxt = FETCH0;
            endcase
         end
         R_EXEC: begin
            alu_srcA_sel = 1'b1;
            alu_op       = r_alu_op;
            aluout_load  = 1'b1;
            state_nxt    = R_WB;
         end
         R_WB: begin
            alu_srcA_sel = 1'b1;
            alu_op       = r_alu_op;
            wreg_sel     = 2'b01;
            reg_write    = 1'b1;
            state_nxt    = FETCH0;
`ifdef OVERFLOW_TRAP_EN
            if (alu_overflow && (funct == FN_ADD || funct == FN_SUB)) begin
               reg_write = 1'b0;
               state_nxt = EXC0;
            end
`endif
         end
         ADDI_EXEC: begin
            alu_srcA_sel = 1'b1;
            alu_srcB_sel = 2'b10;
            alu_op       = ALU_ADD;
            aluout_load  = 1'b1;
            state_nxt    = ADDI_WB;
         end
         ADDI_WB: begin
            alu_srcA_sel = 1'b1;
            alu_srcB_sel = 2'b10;
            alu_op       = ALU_ADD;
            reg_write    = 1'b1;
            state_nxt    = FETCH0;
`ifdef OVERFLOW_TRAP_EN
            if (alu_overflow) begin
               reg_write = 1'b0;
               state_nxt = EXC0;
            end
`endif
         end
         LW_ADDR, SW_ADDR: begin
            alu_srcA_sel = 1'b1;
            alu_srcB_sel = 2'b10;
            alu_op       = ALU_ADD;
            aluout_load  = 1'b1;
            state_nxt    = (state == LW_ADDR) ? LW_MEM : SW_MEM;
         end
         LW_MEM: begin
            mem_addr_sel = 2'b01;
            state_nxt    = LW_WAIT;
         end
         LW_WAIT: begin
            mem_addr_sel = 2'b01;
            state_nxt    = LW_WB;
         end
         LW_WB: begin
            reg_write = 1'b1;
            wdata_sel = 3'b001;
            state_nxt = FETCH0;
         end
         SW_MEM: begin
            mem_write    = 1'b1;
            mem_addr_sel = 2'b01;
            state_nxt    = FETCH0;
         end
         BEQ, BNE: begin
            alu_srcA_sel = 1'b1;
            alu_op       = ALU_SUB;
            pc_src       = 2'b01;
            pc_load      = (state == BEQ) ? alu_zero : ~alu_zero;
            state_nxt    = FETCH0;
         end
         JUMP: begin
            pc_load   = 1'b1;
            pc_src    = 2'b10;
            state_nxt = FETCH0;
         end
`ifdef OVERFLOW_TRAP_EN
         // PC already points past the faulting instruction, so back it off by 4.
         EXC0: begin
            epc_load     = 1'b1;
            alu_srcB_sel = 2'b01;
            alu_op       = ALU_SUB;
            state_nxt    = EXC1;
         end
         EXC1: begin
            pc_load   = 1'b1;
            pc_src    = 2'b11;
            state_nxt = FETCH0;
         end
`endif
         default: state_nxt = RESET;
      endcase
   end

endmodule
